// File: rtl/counter_ctrl_pkg.sv
// Shared types and helpers for the counter-group control front-end.
// Defines event and FSM encodings, the pending-count limit and the quadrature step lookup.
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CLR,
        EV_NEXT,
        EV_PREV,
        EV_INC_FWD,
        EV_INC_REV
    } ctrl_event_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP
    } emit_state_t;

    typedef enum logic [1:0] {
        Q_NONE,
        Q_FWD,
        Q_REV,
        Q_ERR
    } quad_step_t;

    localparam int PEND_MAX = 15;

    // Gray {A,B} -> wheel position 0..3; the position delta modulo 4 gives the step.
    function automatic quad_step_t quad_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] delta;
        delta = {cur_ab[1], ^cur_ab} - {prev_ab[1], ^prev_ab};
        case (delta)
            2'd0:    quad_step = Q_NONE;
            2'd1:    quad_step = Q_FWD;
            2'd3:    quad_step = Q_REV;
            default: quad_step = Q_ERR;
        endcase
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debounce counter.
// The output takes the new level only after DEBOUNCE_CYCLES consecutive differing samples.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            dout   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            if (sync_q[1] == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= sync_q[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl_input.sv
// Operator-control front-end: debounces encoder and buttons, decodes detents and
// emits non-overlapping selector/incrementor/clr strobes with reverse set up and held.
module counter_ctrl_input
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_CYCLES    = 4,
    parameter int GAP_CYCLES      = 4,
    parameter int DETENT_STEPS    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enc_a,
    input  logic enc_b,
    input  logic btn_next,
    input  logic btn_prev,
    input  logic btn_clr,
    output logic selector,
    output logic incrementor,
    output logic clr,
    output logic reverse,
    output logic busy,
    output logic enc_err,
    output logic drop
);

    localparam int AW = $clog2(DETENT_STEPS + 1) + 1;
    localparam logic signed [AW-1:0] ACC_TOP = AW'(DETENT_STEPS - 1);
    localparam logic signed [AW-1:0] ACC_BOT = AW'(1 - DETENT_STEPS);
    localparam logic signed [4:0]    PEND_HI = 5'(PEND_MAX);
    localparam logic signed [4:0]    PEND_LO = 5'(-PEND_MAX);
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    // Bit order: {A, B, next, prev, clr}
    logic [4:0] raw_in;
    logic [4:0] db;
    assign raw_in = {enc_a, enc_b, btn_next, btn_prev, btn_clr};

    for (genvar i = 0; i < 5; i++) begin : g_db
        sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (raw_in[i]),
            .dout (db[i])
        );
    end

    logic [1:0]           ab_q;
    logic [2:0]           btn_q;
    logic [2:0]           btn_rise;
    quad_step_t           step;
    logic signed [AW-1:0] acc;
    logic                 det_fwd;
    logic                 det_rev;

    assign step     = quad_step(ab_q, db[4:3]);
    assign btn_rise = db[2:0] & ~btn_q;
    assign det_fwd  = (step == Q_FWD) && (acc == ACC_TOP);
    assign det_rev  = (step == Q_REV) && (acc == ACC_BOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_q    <= '0;
            btn_q   <= '0;
            acc     <= '0;
            enc_err <= 1'b0;
        end else begin
            ab_q    <= db[4:3];
            btn_q   <= db[2:0];
            enc_err <= (step == Q_ERR);
            if (det_fwd || det_rev) begin
                acc <= '0;
            end else if (step == Q_FWD) begin
                acc <= acc + 1'b1;
            end else if (step == Q_REV) begin
                acc <= acc - 1'b1;
            end
        end
    end

    logic              pend_clr;
    logic              pend_next;
    logic              pend_prev;
    logic signed [4:0] pend_cnt;
    logic signed [4:0] pend_after_take;
    logic              take_clr;
    logic              take_sel;
    logic              take_inc;
    logic              next_set;
    logic              prev_set;

    assign next_set = btn_rise[2] | (pend_next & ~take_sel);
    assign prev_set = btn_rise[1] | (pend_prev & ~take_sel);

    always_comb begin
        pend_after_take = pend_cnt;
        if (take_inc) begin
            pend_after_take = (pend_cnt > 5'sd0) ? pend_cnt - 5'sd1 : pend_cnt + 5'sd1;
        end
    end

    // The event taken this cycle is removed before the new detent is applied,
    // so saturation is judged against what actually remains queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_clr  <= 1'b0;
            pend_next <= 1'b0;
            pend_prev <= 1'b0;
            pend_cnt  <= '0;
            drop      <= 1'b0;
        end else begin
            pend_clr  <= btn_rise[0] | (pend_clr & ~take_clr);
            pend_next <= next_set & ~prev_set;
            pend_prev <= prev_set & ~next_set;
            pend_cnt  <= pend_after_take;
            drop      <= 1'b0;
            if (det_fwd) begin
                if (pend_after_take == PEND_HI) drop <= 1'b1;
                else pend_cnt <= pend_after_take + 5'sd1;
            end else if (det_rev) begin
                if (pend_after_take == PEND_LO) drop <= 1'b1;
                else pend_cnt <= pend_after_take - 5'sd1;
            end
        end
    end

    emit_state_t   state, state_n;
    ctrl_event_t   ev, ev_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          reverse_n;
    logic          sel_n;
    logic          inc_n;
    logic          clr_n;

    always_comb begin
        state_n   = state;
        ev_n      = ev;
        cnt_n     = cnt;
        reverse_n = reverse;
        take_clr  = 1'b0;
        take_sel  = 1'b0;
        take_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_clr) begin
                    ev_n     = EV_CLR;
                    take_clr = 1'b1;
                    state_n  = ST_SETUP;
                end else if (pend_next) begin
                    ev_n      = EV_NEXT;
                    take_sel  = 1'b1;
                    reverse_n = 1'b0;
                    state_n   = ST_SETUP;
                end else if (pend_prev) begin
                    ev_n      = EV_PREV;
                    take_sel  = 1'b1;
                    reverse_n = 1'b1;
                    state_n   = ST_SETUP;
                end else if (pend_cnt != 5'sd0) begin
                    take_inc  = 1'b1;
                    ev_n      = (pend_cnt > 5'sd0) ? EV_INC_FWD : EV_INC_REV;
                    reverse_n = (pend_cnt < 5'sd0);
                    state_n   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_n = ST_PULSE;
                cnt_n   = '0;
            end
            ST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                    ev_n    = EV_NONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        sel_n = (state_n == ST_PULSE) && ((ev_n == EV_NEXT) || (ev_n == EV_PREV));
        inc_n = (state_n == ST_PULSE) && ((ev_n == EV_INC_FWD) || (ev_n == EV_INC_REV));
        clr_n = (state_n == ST_PULSE) && (ev_n == EV_CLR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ev          <= EV_NONE;
            cnt         <= '0;
            reverse     <= 1'b0;
            selector    <= 1'b0;
            incrementor <= 1'b0;
            clr         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            ev          <= ev_n;
            cnt         <= cnt_n;
            reverse     <= reverse_n;
            selector    <= sel_n;
            incrementor <= inc_n;
            clr         <= clr_n;
            busy        <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_counter_ctrl_input.sv
// Randomized self-checking bench: operator actions feed a wheel/detent/event-queue
// model whose expected strobe sequence is compared with what the DUT emits.
module tb_counter_ctrl_input;

    localparam int DB = 4, PW = 2, GW = 2, DS = 4;
    localparam int SAT_PW = 1000, PEND_LIMIT = 15;
    localparam int K_SEL = 1, K_INC = 2, K_CLR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1, rst_n_sat = 1'b1;
    logic enc_a = 1'b0, enc_b = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, btn_clr = 1'b0;
    logic selector, incrementor, clr, reverse, busy, enc_err, drop;
    logic s_selector, s_incrementor, s_clr, s_reverse, s_busy, s_enc_err, s_drop;

    int checks = 0, errors = 0;

    counter_ctrl_input #(
        .DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PW), .GAP_CYCLES(GW), .DETENT_STEPS(DS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_clr(btn_clr),
        .selector(selector), .incrementor(incrementor), .clr(clr), .reverse(reverse),
        .busy(busy), .enc_err(enc_err), .drop(drop)
    );

    // Long pulses keep this instance busy so increments pile up to saturation.
    counter_ctrl_input #(
        .DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(SAT_PW), .GAP_CYCLES(GW), .DETENT_STEPS(DS)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n_sat), .enc_a(enc_a), .enc_b(enc_b),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_clr(btn_clr),
        .selector(s_selector), .incrementor(s_incrementor), .clr(s_clr), .reverse(s_reverse),
        .busy(s_busy), .enc_err(s_enc_err), .drop(s_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int kind;
        int rev;
    } exp_t;
    exp_t exp_q[$];
    int   last_rev = 0;
    int   pos = 0;
    int   acc_m = 0;

    function automatic void expect_ev(input int kind, input int rev);
        exp_t e;
        e.kind = kind;
        if (kind == K_CLR) e.rev = last_rev;
        else begin
            e.rev    = rev;
            last_rev = rev;
        end
        exp_q.push_back(e);
    endfunction

    int n_sel = 0, n_inc = 0, n_clr = 0, n_err = 0, n_drop = 0;
    int low_run = 100, width = 0, hold_left = 0, pulse_rev = 0, prev_rev = 0;
    bit in_pulse = 0;

    always @(negedge clk) begin : mon
        int   nstr;
        int   kind;
        exp_t e;
        if (!rst_n) begin
            in_pulse  = 0;
            low_run   = 100;
            hold_left = 0;
            prev_rev  = 0;
        end else begin
            if (enc_err) n_err++;
            if (drop) n_drop++;
            nstr = int'(selector) + int'(incrementor) + int'(clr);
            if (nstr != 0) check("strobe_onehot", nstr, 1);
            if (nstr != 0 && !in_pulse) begin
                kind = selector ? K_SEL : (incrementor ? K_INC : K_CLR);
                if (kind == K_SEL) n_sel++;
                else if (kind == K_INC) n_inc++;
                else n_clr++;
                check("rev_setup", int'(reverse), prev_rev);
                check("gap_low", int'(low_run >= GW + 1), 1);
                if (exp_q.size() == 0) check("unexpected_pulse", kind, 0);
                else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", kind, e.kind);
                    check("pulse_rev", int'(reverse), e.rev);
                end
                in_pulse  = 1;
                width     = 1;
                pulse_rev = int'(reverse);
            end else if (nstr != 0) begin
                width++;
                check("rev_stable", int'(reverse), pulse_rev);
            end else begin
                if (in_pulse) begin
                    check("pulse_width", width, PW);
                    in_pulse  = 0;
                    low_run   = 0;
                    hold_left = GW;
                end
                low_run++;
                if (hold_left > 0) begin
                    check("rev_hold", int'(reverse), pulse_rev);
                    hold_left--;
                end
            end
            prev_rev = int'(reverse);
        end
    end

    int sat_inc = 0, sat_drop = 0;
    logic sat_prev_inc = 1'b0;
    always @(negedge clk) begin
        if (!rst_n_sat) sat_prev_inc = 1'b0;
        else begin
            if (s_incrementor && !sat_prev_inc) sat_inc++;
            if (s_drop) sat_drop++;
            sat_prev_inc = s_incrementor;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pos_ab(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic enc_step(input int dir, input int hold);
        pos = (pos + dir + 4) % 4;
        {enc_a, enc_b} = pos_ab(pos);
        acc_m += dir;
        if (acc_m == DS) begin
            expect_ev(K_INC, 0);
            acc_m = 0;
        end else if (acc_m == -DS) begin
            expect_ev(K_INC, 1);
            acc_m = 0;
        end
        cyc(hold);
    endtask

    task automatic detent(input int dir, input int hold);
        for (int unsigned i = 0; i < DS; i++) enc_step(dir, hold);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_next = v;
            1:       btn_prev = v;
            default: btn_clr  = v;
        endcase
    endtask

    task automatic press(input int which, input bit bounce, input int hold);
        if (bounce) begin
            for (int unsigned i = 0; i < 3; i++) begin
                set_btn(which, 1'b1);
                cyc(3);
                set_btn(which, 1'b0);
                cyc(3);
            end
        end
        set_btn(which, 1'b1);
        if (which == 2) expect_ev(K_CLR, 0);
        else expect_ev(K_SEL, which);
        cyc(hold);
        set_btn(which, 1'b0);
        cyc(hold);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            cyc(1);
            n++;
        end
        check("idle_reached", int'(n < 300), 1);
        cyc(4);
    endtask

    initial begin : stim
        int base_a, base_b, n, kept, quiet;
        #2 rst_n = 1'b0;
        rst_n_sat = 1'b0;
        cyc(3);
        check("rst_selector", int'(selector), 0);
        check("rst_incrementor", int'(incrementor), 0);
        check("rst_clr", int'(clr), 0);
        check("rst_reverse", int'(reverse), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_enc_err", int'(enc_err), 0);
        check("rst_drop", int'(drop), 0);
        rst_n = 1'b1;
        cyc(50);
        check("idle_outputs", int'({selector, incrementor, clr, reverse, busy, enc_err, drop}), 0);
        check("idle_strobes", n_sel + n_inc + n_clr, 0);

        base_a = n_inc;
        detent(1, 10);
        wait_idle();
        check("cw_detent_count", n_inc - base_a, 1);
        base_a = n_inc;
        detent(-1, 10);
        wait_idle();
        check("ccw_detent_count", n_inc - base_a, 1);

        base_a = n_sel;
        press(0, 1, 10);
        wait_idle();
        check("next_bounce_count", n_sel - base_a, 1);
        press(1, 1, 10);
        wait_idle();
        check("prev_count", n_sel - base_a, 2);

        base_a = n_inc;
        base_b = n_clr;
        detent(1, 8);
        n = 0;
        while (!incrementor && n < 60) begin
            cyc(1);
            n++;
        end
        check("first_pulse_seen", int'(incrementor), 1);
        btn_clr = 1'b1;
        expect_ev(K_CLR, 0);
        cyc(10);
        btn_clr = 1'b0;
        cyc(10);
        detent(1, 8);
        detent(1, 8);
        wait_idle();
        check("queued_inc_count", n_inc - base_a, 3);
        check("queued_clr_count", n_clr - base_b, 1);

        for (int unsigned i = 0; i < 40; i++) begin
            n = $urandom_range(0, 9);
            if (n < 7) begin
                enc_step(($urandom_range(0, 1) == 1) ? 1 : -1, $urandom_range(6, 12));
                if ($urandom_range(0, 3) == 0) begin
                    enc_a = ~enc_a;
                    cyc($urandom_range(1, 3));
                    enc_a = ~enc_a;
                    cyc(2);
                end
            end else begin
                press(n - 7, 1'($urandom_range(0, 1)), $urandom_range(6, 12));
            end
        end
        wait_idle();

        base_a = n_err;
        base_b = n_sel + n_inc + n_clr;
        pos = (pos + 2) % 4;
        {enc_a, enc_b} = pos_ab(pos);
        cyc(12);
        wait_idle();
        check("illegal_err_count", n_err - base_a, 1);
        check("illegal_no_strobe", n_sel + n_inc + n_clr - base_b, 0);
        while (pos != 0) enc_step(1, 8);
        wait_idle();

        btn_next = 1'b1;
        expect_ev(K_SEL, 0);
        n = 0;
        while (!selector && n < 60) begin
            cyc(1);
            n++;
        end
        check("midpulse_seen", int'(selector), 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midpulse_rst_selector", int'(selector), 0);
        check("midpulse_rst_busy", int'(busy), 0);
        btn_next = 1'b0;
        acc_m = 0;
        last_rev = 0;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);

        rst_n_sat = 1'b1;
        cyc(5);
        detent(1, 7);
        n = 0;
        while (!s_incrementor && n < 60) begin
            cyc(1);
            n++;
        end
        check("sat_first_pulse", int'(s_incrementor), 1);
        for (int unsigned i = 0; i < 17; i++) detent(1, 7);
        cyc(10);
        kept = (17 > PEND_LIMIT) ? PEND_LIMIT : 17;
        check("sat_still_first", sat_inc, 1);
        check("sat_drop_count", sat_drop, 17 - kept);
        n = 0;
        quiet = 0;
        while (quiet < 3 && n < 20000) begin
            cyc(1);
            n++;
            quiet = s_busy ? 0 : quiet + 1;
        end
        check("sat_drained", int'(n < 20000), 1);
        check("sat_inc_total", sat_inc, 1 + kept);

        wait_idle();
        check("queue_empty", exp_q.size(), 0);
        check("main_no_drop", n_drop, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
